seq_pattern_tx: RTL and testbench
=================================

Name: seq_pattern_tx

Overview:
Serial pattern transmitter: the stimulus side of the team's serial sequence detectors. It latches a PAT_W-bit pattern (default 3'b101) and shifts it out MSB-first on a one-bit line, repeating it a programmed number of times with an optional idle gap between repeats. Its serial output drives the `in` of a detector instance, both in bench setups and on-chip self-test. Output is Mealy-free: all outputs are registered.

Parameters:
PAT_W, 3, pattern length in bits (>=2)
CNT_W, 4, width of repeat count
GAP_W, 4, width of inter-pattern gap count

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
pattern  input  PAT_W  pattern to send, MSB transmitted first
repeat_cnt  input  CNT_W  number of pattern transmissions (0 = none)
gap  input  GAP_W  idle cycles inserted between consecutive repeats
out  output  1  serial bit; 0 whenever out_valid=0
out_valid  output  1  out carries a pattern bit this cycle
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse at end of job

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset); no asynchronous reset anywhere.
- Reset values: out=0, out_valid=0, busy=0, done=0, state=IDLE, all counters and shadow registers 0.
- States: IDLE, SHIFT, GAP, FIN.
- IDLE: start=1 at edge T latches pattern, repeat_cnt and gap into shadow registers. Inputs are don't-care after T.
  - repeat_cnt!=0: go to SHIFT. In cycle T+1: out=pattern[PAT_W-1], out_valid=1, busy=1.
  - repeat_cnt==0: go to FIN. No valid bits are sent.
- SHIFT: one bit per cycle, MSB to LSB, bit index counter counts PAT_W-1 down to 0. After the LSB cycle, decrement the remaining-repeat count:
  - remaining=0: go to FIN.
  - remaining>0 and gap==0: re-enter SHIFT with the MSB in the very next cycle. Back-to-back patterns have no bubble.
  - remaining>0 and gap>0: go to GAP.
- GAP: exactly `gap` cycles with out_valid=0, out=0, busy=1. Then go to SHIFT.
- FIN: done=1 for exactly one cycle; busy=0 and out_valid=0 in that cycle. Then go to IDLE.
  - Done therefore appears one cycle after the last valid bit, or two cycles after start when repeat_cnt=0.
- start while busy, or in FIN: ignored, not queued.
- Reset mid-job: at the reset edge all outputs clear. No done pulse is generated for the aborted job. The next cycle is IDLE.
- Total valid bits = PAT_W*repeat_cnt.
- Job length from start edge to done cycle = PAT_W*R + gap*(R-1) + 1 cycles, where R = repeat_cnt >= 1.
- Counters are sized by their parameters; widths are explicit, no truncation warnings.
  - repeat counter: CNT_W bits
  - gap counter: GAP_W bits
  - bit index: $clog2(PAT_W) bits
- Overlapping detection is the consumer's concern. The transmitter never alters pattern bits across repeats.

Decomposition:
- Package seq_pkg holds:
  - state encoding typedef (IDLE/SHIFT/GAP/FIN, 2 bits)
  - default pattern constant SEQ_101 = 3'b101, shared with the detector benches
- One natural sub-module: seq_down_counter.
  - Loadable down-counter with load, dec and zero flag, parameterised width.
  - Instantiated twice: repeat count and gap count.
- Bit indexing stays inline in the FSM.

Test Plan:
- Single pattern: pattern=101, repeat=1, gap=0, start at edge 0.
  - Cycles 1-3: out=1,0,1 with out_valid=1.
  - Cycle 4: done=1, busy=0.
- Back-to-back: pattern=101, repeat=2, gap=0.
  - Cycles 1-6: out=101101, all valid, no bubble; done in cycle 7.
  - Chained into the overlapping 101 detector, it must flag twice.
- Gap: pattern=101, repeat=2, gap=2.
  - Cycles 1-3 valid 101; cycles 4-5 out_valid=0, out=0; cycles 6-8 valid 101; done in cycle 9.
- Zero repeat plus ignored start: repeat=0.
  - No out_valid; done in cycle 2.
  - Separately, a second start pulsed mid-job (e.g. cycle 2 of a repeat=3 job) changes nothing; exactly 9 valid bits are sent.
- Reset mid-op: pattern=110, repeat=5, reset asserted at cycle 4.
  - Next cycle: out/out_valid/busy/done all 0 and no done pulse.
  - A fresh start then sends 110 cleanly.
- Parameter sweep: PAT_W=5, pattern=10110, repeat=3, gap=1.
  - Valid stream 10110_10110_10110 with a single 1-cycle bubble between each pattern.
  - done exactly 18 cycles after start.

Source files
------------

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and constants for the serial sequence transmitter/detectors
//
// Purpose: state encoding for seq_pattern_tx and the default pattern shared
// with the detector benches.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    FIN   = 2'd3
  } seq_state_e;

  localparam logic [2:0] SEQ_101 = 3'b101;

endpackage

// File: rtl/seq_down_counter.sv
// rtl/seq_down_counter.sv - loadable down-counter with zero flag
//
// Purpose: holds a remaining-count value; load has priority over dec and the
// counter saturates at zero.
// Ports:
//   clk      - rising-edge clock
//   reset    - synchronous, active-high reset (count clears to 0)
//   load     - load load_val this cycle
//   load_val - value to load
//   dec      - decrement by one (ignored when load is high or count is 0)
//   zero     - count is currently 0
module seq_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern transmitter, MSB-first with repeats and gaps
//
// Purpose: latches a PAT_W-bit pattern and sends it repeat_cnt times on a
// one-bit line, with `gap` idle cycles between repeats. All outputs are
// registered.
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous, active-high reset
//   start      - job request, sampled only in IDLE
//   pattern    - pattern to send, MSB first
//   repeat_cnt - number of pattern transmissions (0 = none)
//   gap        - idle cycles between consecutive repeats
//   out        - serial bit, 0 whenever out_valid is 0
//   out_valid  - out carries a pattern bit
//   busy       - job in progress
//   done       - one-cycle pulse at end of job
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int PAT_W = 3,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             rep_load, rep_dec, rep_zero;
  logic [CNT_W-1:0] rep_val;
  logic             gcnt_load, gcnt_dec, gcnt_zero;
  logic [GAP_W-1:0] gcnt_val;
  logic [IDX_W-1:0] idx_dn;

  // Repeat counter holds the number of repeats still to send after the
  // current one, so the zero flag at the LSB means "this was the last".
  seq_down_counter #(.W(CNT_W)) u_rep_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (rep_load),
    .load_val (rep_val),
    .dec      (rep_dec),
    .zero     (rep_zero)
  );

  // Gap counter holds gap cycles remaining after the current one.
  seq_down_counter #(.W(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (gcnt_load),
    .load_val (gcnt_val),
    .dec      (gcnt_dec),
    .zero     (gcnt_zero)
  );

  assign idx_dn = idx_q - IDX_W'(1);

  // Outputs are computed for the state being entered, so the registered
  // out/out_valid/busy/done line up with state_q in the same cycle.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pat_d       = pat_q;
    gap_d       = gap_q;
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    rep_load    = 1'b0;
    rep_val     = '0;
    rep_dec     = 1'b0;
    gcnt_load   = 1'b0;
    gcnt_val    = '0;
    gcnt_dec    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d    = pattern;
          gap_d    = gap;
          rep_load = 1'b1;
          busy_d   = 1'b1;
          if (repeat_cnt != '0) begin
            rep_val     = repeat_cnt - CNT_W'(1);
            state_d     = SHIFT;
            idx_d       = IDX_MSB;
            out_d       = pattern[PAT_W-1];
            out_valid_d = 1'b1;
          end else begin
            state_d = FIN;
          end
        end
      end

      SHIFT: begin
        busy_d = 1'b1;
        if (idx_q != '0) begin
          idx_d       = idx_dn;
          out_d       = pat_q[idx_dn];
          out_valid_d = 1'b1;
        end else if (rep_zero) begin
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          rep_dec = 1'b1;
          if (gap_q == '0) begin
            idx_d       = IDX_MSB;
            out_d       = pat_q[PAT_W-1];
            out_valid_d = 1'b1;
          end else begin
            state_d   = GAP;
            gcnt_load = 1'b1;
            gcnt_val  = gap_q - GAP_W'(1);
          end
        end
      end

      GAP: begin
        busy_d = 1'b1;
        if (gcnt_zero) begin
          state_d     = SHIFT;
          idx_d       = IDX_MSB;
          out_d       = pat_q[PAT_W-1];
          out_valid_d = 1'b1;
        end else begin
          gcnt_dec = 1'b1;
        end
      end

      FIN: begin
        // A normal job enters FIN with done already raised. A zero-repeat
        // job enters with done low and spends one cycle here to raise it,
        // which places its done pulse two cycles after start.
        if (done_q) begin
          state_d = IDLE;
        end else begin
          done_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      pat_q       <= '0;
      gap_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pat_q       <= pat_d;
      gap_q       <= gap_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - self-checking bench for seq_pattern_tx
module tb_seq_pattern_tx;
  import seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start_a, start_b;
  logic [2:0] pattern_a;
  logic [4:0] pattern_b;
  logic [3:0] repeat_a, repeat_b, gap_a, gap_b;
  logic       out_a, valid_a, busy_a, done_a;
  logic       out_b, valid_b, busy_b, done_b;

  int n_cmp = 0;
  int n_err = 0;

  // Per-cycle tuple {out_valid, out, busy, done}
  logic [3:0] obs[$];
  logic [3:0] exp_q[$];

  seq_pattern_tx #(.PAT_W(3), .CNT_W(4), .GAP_W(4)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .pattern(pattern_a),
    .repeat_cnt(repeat_a), .gap(gap_a), .out(out_a), .out_valid(valid_a),
    .busy(busy_a), .done(done_a)
  );

  seq_pattern_tx #(.PAT_W(5), .CNT_W(4), .GAP_W(4)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .pattern(pattern_b),
    .repeat_cnt(repeat_b), .gap(gap_b), .out(out_b), .out_valid(valid_b),
    .busy(busy_b), .done(done_b)
  );

  // Reference trace for one job, cycle 1 = first cycle after the start edge,
  // followed by two idle cycles.
  task automatic build_exp(input int w, input logic [7:0] pat, input int r, input int g);
    exp_q.delete();
    if (r == 0) begin
      exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0001);
    end else begin
      for (int k = 0; k < r; k++) begin
        for (int i = w - 1; i >= 0; i--) exp_q.push_back({1'b1, pat[i], 2'b10});
        if (k < r - 1) for (int j = 0; j < g; j++) exp_q.push_back(4'b0010);
      end
      exp_q.push_back(4'b0001);
    end
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0000);
  endtask

  task automatic launch(input int sel, input logic [7:0] pat, input int r, input int g);
    if (sel == 0) begin
      pattern_a = pat[2:0]; repeat_a = 4'(r); gap_a = 4'(g); start_a = 1'b1;
    end else begin
      pattern_b = pat[4:0]; repeat_b = 4'(r); gap_b = 4'(g); start_b = 1'b1;
    end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    pattern_a = 3'($urandom); repeat_a = 4'($urandom); gap_a = 4'($urandom);
    pattern_b = 5'($urandom); repeat_b = 4'($urandom); gap_b = 4'($urandom);
  endtask

  task automatic capture(input int sel, input int ncyc, input int mid_start, input int rst_at);
    obs.delete();
    for (int c = 1; c <= ncyc; c++) begin
      obs.push_back(sel == 0 ? {valid_a, out_a, busy_a, done_a} : {valid_b, out_b, busy_b, done_b});
      if (sel == 0) start_a = (c == mid_start);
      else          start_b = (c == mid_start);
      reset = (c == rst_at);
      @(negedge clk);
    end
    start_a = 1'b0;
    start_b = 1'b0;
    reset   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    pattern_a = '0; pattern_b = '0; repeat_a = '0; repeat_b = '0; gap_a = '0; gap_b = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({valid_a, out_a, busy_a, done_a} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_a: vobd got %b exp 0000", {valid_a, out_a, busy_a, done_a});
    end
    n_cmp++;
    if ({valid_b, out_b, busy_b, done_b} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_b: vobd got %b exp 0000", {valid_b, out_b, busy_b, done_b});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    build_exp(3, {5'd0, SEQ_101}, 1, 0);
    launch(0, {5'd0, SEQ_101}, 1, 0);
    capture(0, exp_q.size(), 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL single cycle %0d: vobd got %b exp %b", i + 1, obs[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic bits[$];
    int hits;
    build_exp(3, 8'b101, 2, 0);
    launch(0, 8'b101, 2, 0);
    capture(0, exp_q.size(), 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL back_to_back cycle %0d: vobd got %b exp %b", i + 1, obs[i], exp_q[i]);
      end
    end
    // Overlapping 101 detector on the valid stream
    for (int i = 0; i < obs.size(); i++) if (obs[i][3]) bits.push_back(obs[i][2]);
    hits = 0;
    for (int i = 0; i + 2 < bits.size(); i++)
      if (bits[i] && !bits[i + 1] && bits[i + 2]) hits++;
    n_cmp++;
    if (hits != 2) begin
      n_err++;
      $display("FAIL back_to_back detect: got %0d hits exp 2", hits);
    end
  endtask

  task automatic test_gap();
    build_exp(3, 8'b101, 2, 2);
    launch(0, 8'b101, 2, 2);
    capture(0, exp_q.size(), 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL gap cycle %0d: vobd got %b exp %b", i + 1, obs[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_zero_repeat();
    build_exp(3, 8'b101, 0, 3);
    launch(0, 8'b101, 0, 3);
    capture(0, exp_q.size(), 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL zero_repeat cycle %0d: vobd got %b exp %b", i + 1, obs[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_ignored_start();
    int nvalid;
    // start pulsed in cycle 2 of a busy job
    build_exp(3, 8'b101, 3, 0);
    launch(0, 8'b101, 3, 0);
    capture(0, exp_q.size(), 2, 0);
    nvalid = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (obs[i][3]) nvalid++;
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL ignored_start_busy cycle %0d: vobd got %b exp %b", i + 1, obs[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (nvalid != 9) begin
      n_err++;
      $display("FAIL ignored_start_count: got %0d valid bits exp 9", nvalid);
    end
    // start pulsed in the done cycle
    build_exp(3, 8'b011, 1, 0);
    launch(0, 8'b011, 1, 0);
    capture(0, exp_q.size(), 4, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL ignored_start_fin cycle %0d: vobd got %b exp %b", i + 1, obs[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    build_exp(3, 8'b110, 5, 0);
    while (exp_q.size() > 4) void'(exp_q.pop_back());
    repeat (4) exp_q.push_back(4'b0000);
    launch(0, 8'b110, 5, 0);
    capture(0, exp_q.size(), 0, 4);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL reset_mid cycle %0d: vobd got %b exp %b", i + 1, obs[i], exp_q[i]);
      end
    end
    build_exp(3, 8'b110, 1, 0);
    launch(0, 8'b110, 1, 0);
    capture(0, exp_q.size(), 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL reset_fresh cycle %0d: vobd got %b exp %b", i + 1, obs[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_sweep();
    int done_at;
    build_exp(5, 8'b10110, 3, 1);
    launch(1, 8'b10110, 3, 1);
    capture(1, exp_q.size(), 0, 0);
    done_at = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (obs[i][0] && done_at < 0) done_at = i + 1;
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL sweep cycle %0d: vobd got %b exp %b", i + 1, obs[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (done_at != 18) begin
      n_err++;
      $display("FAIL sweep_done_latency: got %0d exp 18", done_at);
    end
  endtask

  task automatic test_random();
    int sel, r, g, w;
    logic [7:0] pat;
    for (int job = 0; job < 10; job++) begin
      sel = job % 2;
      w   = (sel == 0) ? 3 : 5;
      pat = 8'($urandom);
      r   = int'($urandom_range(0, 4));
      g   = int'($urandom_range(0, 3));
      build_exp(w, pat, r, g);
      launch(sel, pat, r, g);
      capture(sel, exp_q.size(), 0, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (obs[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL random job %0d (w=%0d pat=%b r=%0d g=%0d) cycle %0d: vobd got %b exp %b",
                   job, w, pat, r, g, i + 1, obs[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_zero_repeat();
    test_ignored_start();
    test_reset_mid();
    test_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
